// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one 4-bit nibble per clock, valid/ready on both sides.
// Optional `OVERFLOW_FLAG_EN adds out_ovf (signed two's-complement overflow).
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] nib_idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [IDX_W+1:0] nib_lsb;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_nib;

  // 4-bit ripple slice on the nibble selected by nib_idx
  always_comb begin
    nib_lsb        = {nib_idx, 2'b00};
    a_nib          = a_q[nib_lsb +: 4];
    b_nib          = b_q[nib_lsb +: 4];
    {c_nib, s_nib} = 5'(a_nib) + 5'(b_nib) + 5'(carry);
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_nib;

  // Same-signed operands producing an opposite-signed MSB: equals carry-in XOR carry-out of the MSB
  always_comb begin
    ovf_nib = (a_nib[3] ~^ b_nib[3]) & (s_nib[3] ^ a_nib[3]);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      nib_idx   <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry    <= in_cin;
            nib_idx  <= '0;
            out_sum  <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          out_sum[nib_lsb +: 4] <= s_nib;
          carry                 <= c_nib;
          nib_idx               <= nib_idx + 1'b1;
          if (nib_idx == LAST_IDX) begin
            out_cout  <= c_nib;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef OVERFLOW_FLAG_EN
            out_ovf   <= ovf_nib;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
